// File: rtl/morty_ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shared shift/add
// datapath, one bit per cycle, stalls ID/EX while busy and emits a one-cycle result.
module morty_ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] port_a_i,
    input  logic [XLEN-1:0] port_b_i,
    input  logic [4:0]      rd_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] hi, lo, mag;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q, rd_out;

    logic            accept, a_signed, b_signed, neg_a, neg_b, neg_res;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] hi_nxt, lo_nxt, div_val, div_res, final_res;
    logic [2*XLEN-1:0] prod, prod_s;

    assign accept = (state == IDLE) & start_i & ~kill_i;
    assign busy_o = accept | (state == CALC);
    assign done_o = (state == DONE) & ~kill_i;
    assign result_o = result_q;
    assign rd_o     = rd_out;

    // Operand decode at acceptance: signedness, magnitudes and special cases.
    always_comb begin
        a_signed = ~((op_i == 3'd3) | (op_i[2] & op_i[0]));
        b_signed = ~(op_i[1] & ~op_i[2]) & ~(op_i[2] & op_i[0]);
        neg_a    = a_signed & port_a_i[XLEN-1];
        neg_b    = b_signed & port_b_i[XLEN-1];
        a_mag    = neg_a ? -port_a_i : port_a_i;
        b_mag    = neg_b ? -port_b_i : port_b_i;
        // Remainders follow the dividend's sign; everything else the sign product.
        neg_res  = (op_i[2] & op_i[1]) ? neg_a : (neg_a ^ neg_b);
        div_zero = op_i[2] & (port_b_i == '0);
        div_ovf  = op_i[2] & ~op_i[0] & (port_a_i == MIN_INT) & (port_b_i == '1);
        special_res = div_zero ? (op_i[1] ? port_a_i : '1)
                               : (op_i[1] ? '0 : MIN_INT);
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        hi_nxt    = hi;
        lo_nxt    = lo;
        if (op_q[2]) begin
            div_shift = {hi, lo[XLEN-1]};
            div_diff  = div_shift - {1'b0, mag};
            hi_nxt    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_nxt    = {lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
            hi_nxt  = mul_sum[XLEN:1];
            lo_nxt  = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod      = {hi_nxt, lo_nxt};
        prod_s    = neg_q ? -prod : prod;
        div_val   = op_q[1] ? hi_nxt : lo_nxt;
        div_res   = neg_q ? -div_val : div_val;
        final_res = op_q[2] ? div_res
                  : (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            mag      <= '0;
            result_q <= '0;
            rd_q     <= '0;
            rd_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op_i;
                        rd_q  <= rd_i;
                        neg_q <= neg_res;
                        if (div_zero | div_ovf) begin
                            result_q <= special_res;
                            rd_out   <= rd_i;
                            state    <= DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= op_i[2] ? a_mag : b_mag;
                            mag   <= op_i[2] ? b_mag : a_mag;
                            cnt   <= CNT_W'(XLEN);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        state <= IDLE;
                    end else begin
                        hi  <= hi_nxt;
                        lo  <= lo_nxt;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            result_q <= final_res;
                            rd_out   <= rd_q;
                            state    <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morty_ex_muldiv.sv
// Self-checking bench for morty_ex_muldiv: directed RV32M corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_morty_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] port_a_i = '0;
    logic [31:0] port_b_i = '0;
    logic [4:0]  rd_i = '0;
    logic        kill_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    morty_ex_muldiv dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .port_a_i(port_a_i), .port_b_i(port_b_i), .rd_i(rd_i), .kill_i(kill_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = a;
        sb = b;
        ea = {32'b0, a};
        eb = {32'b0, b};
        if (op == MUL || op == MULH || op == MULHSU) ea = {{32{a[31]}}, a};
        if (op == MUL || op == MULH) eb = {{32{b[31]}}, b};
        p = ea * eb;
        case (op)
            MUL:    return p[31:0];
            MULH, MULHSU, MULHU: return p[63:32];
            DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op at a negedge and follow it to done_o; operands are scrambled
    // after acceptance, and start_i is optionally held through the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit hold);
        int lat, cyc;
        int exp_lat;
        exp_lat = ref_latency(op, a, b);
        lat = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; port_a_i = a; port_b_i = b; rd_i = rd;
        #1 check("busy_accept", {31'b0, busy_o}, 32'd1);
        for (cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = cyc;
                check("busy_in_done", {31'b0, busy_o}, 32'd0);
                check("result", result_o, exp);
                check("rd", {27'b0, rd_o}, {27'b0, rd});
            end else if (cyc < exp_lat && (cyc == 1 || cyc == exp_lat - 1)) begin
                check("busy_calc", {31'b0, busy_o}, 32'd1);
            end
            if (!hold) start_i = 1'b0;
            port_a_i = $urandom;
            port_b_i = $urandom;
        end
        check("latency", lat, exp_lat);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("extra_done", {31'b0, done_o}, 32'd0);
        end
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int dones;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 if (done_o) dones++;
        end
        check(tag, dones, 0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int sel;

        #2 rst = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_rd", {27'b0, rd_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(MUL,    32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1'b0);
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 1'b0);
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 1'b0);
        run_op(MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0);
        run_op(DIV,    32'd100,       32'd0,         5'd7,  32'hFFFF_FFFF, 1'b0);
        run_op(REMU,   32'd100,       32'd0,         5'd8,  32'd100,       1'b0);
        run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1'b0);
        run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1'b0);
        run_op(DIV,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, 1'b0);
        run_op(REM,    32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, 1'b0);
        run_op(DIVU,   32'hFFFF_FFF9, 32'd2,         5'd13, 32'h7FFF_FFFC, 1'b1);
        run_op(DIV,    32'd100,       32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1);

        // Kill mid-CALC: busy drops the next cycle and no result ever appears.
        @(negedge clk);
        start_i = 1'b1; op_i = DIVU; port_a_i = 32'd1000; port_b_i = 32'd7; rd_i = 5'd15;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1 start_i = 1'b0;
            if (done_o) check("kill_early_done", 32'd1, 32'd0);
        end
        kill_i = 1'b1;
        @(posedge clk);
        #1 check("kill_busy", {31'b0, busy_o}, 32'd0);
        kill_i = 1'b0;
        expect_no_done("kill_no_done", 40);
        run_op(DIVU, 32'd1000, 32'd7, 5'd16, 32'd142, 1'b0);

        // Kill during DONE suppresses done_o that very cycle.
        @(negedge clk);
        start_i = 1'b1; op_i = MUL; port_a_i = 32'd9; port_b_i = 32'd9; rd_i = 5'd17;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1 start_i = 1'b0;
        end
        @(posedge clk);
        #1 check("done_before_kill", {31'b0, done_o}, 32'd1);
        kill_i = 1'b1;
        #1 check("kill_in_done", {31'b0, done_o}, 32'd0);
        @(negedge clk);
        kill_i = 1'b0;
        expect_no_done("kill_done_quiet", 5);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start_i = 1'b1; op_i = MULHU; port_a_i = 32'h1234_5678; port_b_i = 32'h9ABC_DEF0; rd_i = 5'd18;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1 start_i = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        check("midrst_rd", {27'b0, rd_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_no_done("midrst_no_done", 40);
        run_op(REM, 32'd17, 32'hFFFF_FFFB, 5'd19, 32'd2, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = $urandom_range(0, 50) - 25; b = $urandom_range(0, 10) - 5; end
            run_op(op, a, b, 5'($urandom), ref_model(op, a, b), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
